// File: rtl/adv7185_init_pkg.sv
// Shared constants for the ADV7185 register-init sequencer: FSM encoding, device address, init table.
// Latency: n/a (constants only).
// Backpressure: n/a.
package adv7185_init_pkg;

    // FSM encoding kept as plain constants so legacy tools and waveform viewers see stable values
    typedef logic [3:0] state_t;

    localparam state_t ST_STARTUP    = 4'd0;
    localparam state_t ST_WAIT_START = 4'd1;
    localparam state_t ST_CHECK      = 4'd2;
    localparam state_t ST_ADDR       = 4'd3;
    localparam state_t ST_SUB        = 4'd4;
    localparam state_t ST_VAL        = 4'd5;
    localparam state_t ST_STOP       = 4'd6;
    localparam state_t ST_GAP        = 4'd7;
    localparam state_t ST_DONE       = 4'd8;

    // 8-bit write address of the ADV7185, R/W bit = 0
    localparam logic [7:0] DEF_DEV_ADDR = 8'h8A;

    // Table depth is a power of two so the ROM index is a clean bit slice
    localparam int TABLE_AW  = 4;
    localparam int TABLE_LEN = 1 << TABLE_AW;

    // Each entry is {subaddress, value}
    localparam logic [15:0] INIT_TABLE [TABLE_LEN] = '{
        16'h00_04, 16'h01_88, 16'h02_04, 16'h03_0C,
        16'h04_D4, 16'h05_00, 16'h07_40, 16'h08_80,
        16'h09_80, 16'h0A_00, 16'h0B_00, 16'h0C_36,
        16'h0E_00, 16'h0F_00, 16'h10_00, 16'h11_00
    };

    // Counter width that covers the larger of the two delays, never narrower than 1 bit
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/adv7185_init_rom.sv
// Combinational init-table lookup: reg_index -> {subaddr, value}; entries past the table read as zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module adv7185_init_rom
    import adv7185_init_pkg::*;
(
    input  logic [7:0] idx,
    output logic [7:0] subaddr,
    output logic [7:0] value
);

    // Table lookup, out-of-range indices return 0
    always_comb begin
        subaddr = 8'h00;
        value   = 8'h00;
        if (idx[7:TABLE_AW] == '0) begin
            {subaddr, value} = INIT_TABLE[idx[TABLE_AW-1:0]];
        end
    end

endmodule

// File: rtl/adv7185_init_seq.sv
// Walks the init table, issuing one 3-byte I2C write (dev addr, subaddr, value) per entry to the byte engine.
// Latency: one cycle per state hop; ack at edge N presents the next byte at edge N+1.
// Backpressure: each byte is held until the engine pulses i2c_ack; transactions wait for i2c_idle.
module adv7185_init_seq
    import adv7185_init_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR       = DEF_DEV_ADDR,
    parameter int         NUM_REGS       = 16,
    parameter int         STARTUP_CYCLES = 4096,
    parameter int         GAP_CYCLES     = 64,
    parameter bit         AUTO_START     = 1'b1
)(
    input  logic       clock4x,
    input  logic       reset_n,
    input  logic       start,
    input  logic       i2c_ack,
    input  logic       i2c_idle,
    output logic       i2c_load,
    output logic [7:0] i2c_data,
    output logic [7:0] reg_index,
    output logic       busy,
    output logic       done
);

    localparam int             CW           = cnt_width(STARTUP_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0]  STARTUP_LOAD = CW'(STARTUP_CYCLES);
    localparam logic [CW-1:0]  GAP_LOAD     = CW'(GAP_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE      = CW'(1);
    localparam logic [7:0]     LAST_IDX     = 8'(NUM_REGS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          load_q,  load_d;
    logic [7:0]    data_q,  data_d;
    logic [7:0]    idx_q,   idx_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic [7:0]    rom_sub;
    logic [7:0]    rom_val;

    adv7185_init_rom u_rom (
        .idx     (idx_q),
        .subaddr (rom_sub),
        .value   (rom_val)
    );

    // Next-state logic: FSM, shared STARTUP/GAP counter and registered engine outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        data_d  = data_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == '0) begin
                    if (AUTO_START) begin
                        state_d = ST_CHECK;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_START;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT_START, ST_DONE: begin
                if (start) begin
                    state_d = ST_CHECK;
                    idx_d   = 8'h00;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_CHECK: begin
                if (i2c_idle) begin
                    state_d = ST_ADDR;
                    load_d  = 1'b1;
                    data_d  = DEV_ADDR;
                end
            end
            ST_ADDR: begin
                if (i2c_ack) begin
                    state_d = ST_SUB;
                    data_d  = rom_sub;
                end
            end
            ST_SUB: begin
                if (i2c_ack) begin
                    state_d = ST_VAL;
                    data_d  = rom_val;
                end
            end
            ST_VAL: begin
                // Dropping load on the value ack makes the engine close with a stop
                if (i2c_ack) begin
                    state_d = ST_STOP;
                    load_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (i2c_idle) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                // GAP lasts GAP_CYCLES cycles (at least one) counted from entry
                if (cnt_q <= CNT_ONE) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CHECK;
                        idx_d   = idx_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STARTUP;
                cnt_d   = STARTUP_LOAD;
                load_d  = 1'b0;
                data_d  = 8'h00;
                idx_d   = 8'h00;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops every output at once and re-arms the startup wait
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_STARTUP;
            cnt_q   <= STARTUP_LOAD;
            load_q  <= 1'b0;
            data_q  <= 8'h00;
            idx_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign i2c_load  = load_q;
    assign i2c_data  = data_q;
    assign reg_index = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/adv7185_init_seq.md
# adv7185_init_seq

Register-write sequencer that sits directly upstream of the ADV7185 I2C byte engine. After reset, or on request, it walks a constant table of (subaddress, value) pairs. Each pair is issued as one three-byte I2C write transaction (device address, subaddress, value) through the engine's load/ack/idle byte handshake. It runs in the same clock4x domain as the engine and reports busy and done to the video front-end controller.

## Interface
- DEV_ADDR, 8'h8A: 8-bit write address of the ADV7185 (R/W bit = 0).
- NUM_REGS, 16: number of table entries issued, 1..256.
- STARTUP_CYCLES, 4096: clock4x cycles to wait after reset release before the first transaction. Value 0 means no wait.
- GAP_CYCLES, 64: idle cycles inserted after each stop condition before the next transaction.
- AUTO_START, 1: 1 means run the table once after reset without waiting for start.

- clock4x  in  1  engine clock; everything is sampled on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to (re)run the whole table. Honoured only in DONE or WAIT_START.
- i2c_ack  in  1  one-cycle pulse from the engine: the presented byte has been latched.
- i2c_idle  in  1  high while the engine sits in its idle state (bus released).
- i2c_load  out  1  byte-request strobe to the engine. Held high across bytes of one transaction.
- i2c_data  out  8  byte presented to the engine. Stable whenever i2c_load = 1.
- reg_index  out  8  table entry currently being written.
- busy  out  1  high from sequence start until the last GAP completes.
- done  out  1  high after the full table has been written. Cleared on start.

## Operation
- States:
  - STARTUP: count STARTUP_CYCLES. Then go to CHECK if AUTO_START=1, else WAIT_START.
  - WAIT_START: wait for start.
  - CHECK: wait for i2c_idle = 1.
  - ADDR: i2c_load = 1, i2c_data = DEV_ADDR; wait for ack.
  - SUB: i2c_data = table subaddress; wait for ack.
  - VAL: i2c_data = table value; wait for ack.
  - STOP: i2c_load = 0; wait for i2c_idle = 1.
  - GAP: count GAP_CYCLES.
  - After GAP: if reg_index = NUM_REGS-1, go to DONE; else increment reg_index and go to CHECK.
  - DONE: stay here until start. On start: reg_index = 0, done = 0, go to CHECK.
- i2c_load behaviour:
  - Rises on entry to ADDR.
  - Stays high through SUB, so the engine chains bytes with no stop condition between them.
  - Falls on the edge that samples ack in VAL, so the engine issues a stop after the value byte.
- Table ROM is combinational, indexed by reg_index: {subaddr[7:0], value[7:0]}.
- Ignored inputs:
  - i2c_ack outside ADDR/SUB/VAL is ignored.
  - start outside WAIT_START/DONE is ignored; no queuing.
- start asserted in the same cycle as the final GAP completion: ignored. The block enters DONE and needs a fresh start.
- Reset mid-transaction: all outputs return to reset values immediately and the state goes to STARTUP. The engine shares reset_n, so no partial-transaction recovery is needed.
- reg_index wrap: cannot occur. NUM_REGS ≤ 256 and the increment happens only when reg_index < NUM_REGS-1.

## Timing
- Reset values: i2c_load = 0, i2c_data = 8'h00, reg_index = 0, busy = 0, done = 0.
- busy:
  - Rises one cycle after leaving STARTUP with AUTO_START = 1, or one cycle after start is sampled.
  - Falls on the same edge that done rises.
- ack to next byte: ack sampled high at edge N gives the new i2c_data at edge N+1. This is far ahead of the engine's next-byte sample point, about 35 cycles later.
- Byte-to-byte latency is set by the engine; the sequencer adds exactly 1 cycle per state hop.
- Minimum time between consecutive transactions: stop, then i2c_idle observed, then GAP_CYCLES + 1 cycles before i2c_load rises again.
- Counters are $clog2(max(STARTUP_CYCLES, GAP_CYCLES) + 1) bits wide and saturate-free. Each counter reloads on state entry.

## Structure
- Package adv7185_init_pkg holds:
  - the state enum;
  - the default DEV_ADDR;
  - the table as a constant array of 16-bit {subaddr, value} entries.
- One sub-module, adv7185_init_rom: combinational lookup taking reg_index to {subaddr, value}, built from the package array.
- Top level contains the FSM, the STARTUP/GAP counter and the output registers.

## Test plan
- Reset release, STARTUP_CYCLES = 8, AUTO_START = 1, engine model acks 30 cycles after each load:
  - first i2c_load rises 10 cycles after release with i2c_data = 8'h8A;
  - then 8'h00, then table[0].value;
  - i2c_load falls one cycle after the third ack.
- NUM_REGS = 3: model records exactly 3 transactions, each as byte triplets {8A, sub, val}. done = 1 and busy = 0 after the third GAP.
- Hold i2c_idle = 0 for 200 cycles in CHECK: i2c_load stays 0 until idle rises, then asserts the next cycle.
- Pulse start in DONE: reg_index = 0, done = 0, and the full table replays. Pulse start during VAL: no effect on the ongoing sequence.
- Drive spurious i2c_ack in GAP and STOP: no state change, i2c_load stays 0.
- Assert reset_n = 0 for 1 cycle in SUB: i2c_load = 0 asynchronously, then the STARTUP delay restarts and the table restarts from entry 0.
